// File: rtl/qadd_pkg.sv
// Shared types and helpers for the qadd arbiter and its adder core.
package qadd_pkg;

  // Control states of the arbiter/sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } qadd_state_e;

  // Default word width and the position of its sign bit.
  localparam int QADD_N    = 32;
  localparam int QADD_SIGN = QADD_N - 1;

  // Sign bit after -0 normalization: a zero magnitude always carries a + sign.
  function automatic logic sm_neg0_fix(input logic sign, input logic mag_zero);
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder. Magnitude overflow wraps; callers
// that need saturation detect it themselves.
module qadd #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  // A fraction field wider than the magnitude has no valid encoding.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("qadd: Q must lie in [0, N-1]");
  end

  logic [N-2:0] a_mag, b_mag;
  assign a_mag = a[N-2:0];
  assign b_mag = b[N-2:0];

  // Same signs add magnitudes; differing signs subtract the smaller
  // magnitude from the larger and take the larger operand's sign.
  always_comb begin
    if (a[N-1] == b[N-1]) begin
      c = {a[N-1], a_mag + b_mag};
    end else if (a_mag >= b_mag) begin
      c = {a[N-1], a_mag - b_mag};
    end else begin
      c = {b[N-1], b_mag - a_mag};
    end
  end

endmodule

// File: rtl/qadd_arbiter.sv
// Round-robin arbiter for two clients sharing one qadd instance.
// One operation in flight at a time: IDLE accepts, EXEC computes and
// registers the result, RESP holds it until the consumer takes it.
module qadd_arbiter
  import qadd_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = QADD_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_b1,
  input  logic [1:0]   req_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_c,
  output logic         rsp_ovf,
  output logic         busy
);

  localparam int SGN = N - 1;

  qadd_state_e  state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_c_q, rsp_c_d;
  logic         rsp_ovf_q, rsp_ovf_d;

  logic         grant, any_vld, sel_sub;
  logic [N-1:0] sel_a, sel_b;
  logic [N-1:0] sum_raw, sum_fix;
  logic         ovf;

  // Grant selection: alternate on contention, otherwise whoever is valid.
  always_comb begin
    any_vld = |req_valid;
    if (&req_valid) grant = ~last_grant_q;
    else            grant = req_valid[1];
    req_ready = 2'b00;
    if (!rst && state_q == IDLE && any_vld) req_ready[grant] = 1'b1;
  end

  assign sel_a   = grant ? req_a1 : req_a0;
  assign sel_b   = grant ? req_b1 : req_b0;
  assign sel_sub = req_sub[grant];

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a (a_q),
    .b (b_q),
    .c (sum_raw)
  );

  // Overflow when effective signs match and a_mag + b_mag >= 2^(N-1),
  // i.e. a_mag exceeds the headroom left by b_mag (~b_mag).
  always_comb begin
    ovf = (a_q[SGN] == b_q[SGN]) && (a_q[N-2:0] > ~b_q[N-2:0]);
    sum_fix = {sm_neg0_fix(sum_raw[SGN], sum_raw[N-2:0] == '0), sum_raw[N-2:0]};
  end

  // Next-state and register-load decisions.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_c_d      = rsp_c_q;
    rsp_ovf_d    = rsp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          a_d     = sel_a;
          b_d     = {sel_b[SGN] ^ sel_sub, sel_b[N-2:0]};
          id_d    = grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_c_d      = ovf ? {a_q[SGN], {(N-1){1'b1}}} : sum_fix;
        rsp_ovf_d    = ovf;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        last_grant_d = id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_c_q      <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_c_q      <= rsp_c_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qadd_arbiter.sv
// Directed bench for qadd_arbiter: arithmetic, arbitration, backpressure, reset.
module tb_qadd_arbiter;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, req_sub;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic [31:0] rsp_c;

  int checks = 0;
  int passed = 0;

  qadd_arbiter #(.Q(15), .N(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else         begin req_a1 = a; req_b1 = b; end
    req_sub[id]   = sub;
    req_valid[id] = 1'b1;
  endtask

  // Wait (bounded) for ready on requester id at a negedge; timeout gives ok=0.
  task automatic wait_ready(input int id, output bit ok);
    int n;
    ok = 1; n = 0;
    @(negedge clk);
    while (!req_ready[id]) begin
      n++;
      if (n > 20) begin ok = 0; break; end
      @(negedge clk);
    end
  endtask

  // Count negedges after the accept edge until rsp_valid (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 12);
  endtask

  // One full operation with rsp_ready held high; returns captured response.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] c, output logic rid, output logic ovf, output int lat);
    bit ok;
    start_req(id, a, b, sub);
    wait_ready(id, ok);
    if (!ok) begin
      req_valid = 2'b00; lat = 99; c = 'x; rid = 'x; ovf = 'x;
      return;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_rsp(lat);
    c = rsp_c; rid = rsp_id; ovf = rsp_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 2'b11; rsp_ready = 1;
    #12;
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_c !== 32'h0) $display("FAIL reset_rsp_c: got %h want 0", rsp_c); else passed++;
    checks++; if ({rsp_id, rsp_ovf, busy} !== 3'b000) $display("FAIL reset_id_ovf_busy: got %b want 000", {rsp_id, rsp_ovf, busy}); else passed++;
    req_valid = 2'b00;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) $display("FAIL post_reset_idle_ready: got %b want 00", req_ready); else passed++;
  endtask

  task automatic test_add;
    logic [31:0] c; logic rid, ovf; int lat;
    @(posedge clk); #1;
    run_op(0, 32'h0000C000, 32'h00012000, 1'b0, c, rid, ovf, lat);
    checks++; if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat); else passed++;
    checks++; if (c !== 32'h0001E000) $display("FAIL add_c: got %h want 0001e000", c); else passed++;
    checks++; if ({rid, ovf} !== 2'b00) $display("FAIL add_id_ovf: got %b want 00", {rid, ovf}); else passed++;
  endtask

  task automatic test_sub;
    logic [31:0] c; logic rid, ovf; int lat;
    run_op(1, 32'h0000C000, 32'h00012000, 1'b1, c, rid, ovf, lat);
    checks++; if (lat !== 2) $display("FAIL sub_latency: got %0d want 2", lat); else passed++;
    checks++; if (c !== 32'h80006000) $display("FAIL sub_c: got %h want 80006000", c); else passed++;
    checks++; if ({rid, ovf} !== 2'b10) $display("FAIL sub_id_ovf: got %b want 10", {rid, ovf}); else passed++;
  endtask

  task automatic test_ovf_zero;
    logic [31:0] va [6], vb [6], ec [6];
    logic        vs [6], eo [6];
    logic [31:0] c; logic rid, ovf; int lat;
    va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; vs[0] = 0; ec[0] = 32'h7FFFFFFF; eo[0] = 1;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; vs[1] = 0; ec[1] = 32'h00000000; eo[1] = 0;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'h80000001; vs[2] = 0; ec[2] = 32'hFFFFFFFF; eo[2] = 1;
    va[3] = 32'h40000000; vb[3] = 32'h3FFFFFFF; vs[3] = 0; ec[3] = 32'h7FFFFFFF; eo[3] = 0;
    va[4] = 32'h40000000; vb[4] = 32'hC0000000; vs[4] = 1; ec[4] = 32'h7FFFFFFF; eo[4] = 1;
    va[5] = 32'h80004000; vb[5] = 32'h00004000; vs[5] = 0; ec[5] = 32'h00000000; eo[5] = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(i % 2, va[i], vb[i], vs[i], c, rid, ovf, lat);
      checks++;
      if (c !== ec[i] || ovf !== eo[i] || lat !== 2)
        $display("FAIL ovf_zero_%0d: got c=%h ovf=%b lat=%0d want c=%h ovf=%b lat=2", i, c, ovf, lat, ec[i], eo[i]);
      else passed++;
    end
  endtask

  task automatic test_contention;
    int ids [4], cyc [4], n, twohot;
    logic [31:0] c0;
    n = 0; twohot = 0; c0 = '0;
    rst = 1; req_valid = 2'b00; rsp_ready = 1;
    #3;
    @(posedge clk); #2 rst = 0;
    req_a0 = 32'h00010000; req_b0 = 32'h00010000;
    req_a1 = 32'h00020000; req_b1 = 32'h00008000;
    req_sub = 2'b00; req_valid = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (req_ready == 2'b11) twohot++;
      if (rsp_valid && n < 4) begin
        ids[n] = rsp_id; cyc[n] = k;
        if (n == 0) c0 = rsp_c;
        n++;
      end
    end
    req_valid = 2'b00;
    checks++; if (n !== 4) $display("FAIL cont_count: got %0d want 4", n); else passed++;
    checks++; if (twohot !== 0) $display("FAIL cont_twohot: got %0d want 0", twohot); else passed++;
    checks++; if (c0 !== 32'h00020000) $display("FAIL cont_first_c: got %h want 00020000", c0); else passed++;
    if (n == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (ids[i] !== i % 2) $display("FAIL cont_id_%0d: got %0d want %0d", i, ids[i], i % 2); else passed++;
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (cyc[i] - cyc[i-1] !== 3) $display("FAIL cont_spacing_%0d: got %0d want 3", i, cyc[i] - cyc[i-1]); else passed++;
      end
    end
    // Let any in-flight op drain before the next test.
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    bit ok; int lat; bit stable, rdy_bad, busy_bad;
    logic [31:0] c0; logic id0;
    stable = 1; rdy_bad = 0; busy_bad = 0;
    rsp_ready = 0;
    start_req(0, 32'h00001000, 32'h00002000, 1'b0);
    wait_ready(0, ok);
    @(posedge clk); #1 req_valid = 2'b11;
    wait_rsp(lat);
    c0 = rsp_c; id0 = rsp_id;
    checks++; if (c0 !== 32'h00003000 || lat !== 2) $display("FAIL bp_result: got c=%h lat=%0d want 00003000 lat=2", c0, lat); else passed++;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_c !== c0 || rsp_id !== id0) stable = 0;
      if (req_ready !== 2'b00) rdy_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
    end
    checks++; if (!stable) $display("FAIL bp_stable: got unstable rsp want held"); else passed++;
    checks++; if (rdy_bad) $display("FAIL bp_req_ready: got nonzero want 00"); else passed++;
    checks++; if (busy_bad) $display("FAIL bp_busy: got 0 want 1"); else passed++;
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL bp_release: got busy/valid=%b want 00", {busy, rsp_valid}); else passed++;
    checks++; if (req_ready === 2'b00) $display("FAIL bp_idle_ready: got 00 want one-hot"); else passed++;
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_exec;
    logic [31:0] c; logic rid, ovf; int lat; bit ok;
    run_op(0, 32'h00000100, 32'h00000100, 1'b0, c, rid, ovf, lat);
    start_req(0, 32'h00004000, 32'h00004000, 1'b0);
    wait_ready(0, ok);
    @(posedge clk); #1 req_valid = 2'b11;
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready, rsp_id, rsp_ovf} !== 5'b0 || rsp_c !== 32'h0)
      $display("FAIL rst_exec_outs: got busy=%b v=%b rdy=%b c=%h want all 0", busy, rsp_valid, req_ready, rsp_c);
    else passed++;
    @(posedge clk); #3 rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL rst_exec_grant: got %b want 01", req_ready); else passed++;
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_resp;
    bit ok; int lat;
    rsp_ready = 0;
    start_req(0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_ready(0, ok);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(lat);
    checks++; if (rsp_valid !== 1'b1 || rsp_ovf !== 1'b1) $display("FAIL rst_resp_pre: got v=%b ovf=%b want 1 1", rsp_valid, rsp_ovf); else passed++;
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready, rsp_id, rsp_ovf} !== 5'b0 || rsp_c !== 32'h0)
      $display("FAIL rst_resp_outs: got busy=%b v=%b ovf=%b c=%h want all 0", busy, rsp_valid, rsp_ovf, rsp_c);
    else passed++;
    req_valid = 2'b11; rsp_ready = 1;
    @(posedge clk); #4 rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL rst_resp_grant: got %b want 01", req_ready); else passed++;
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1; req_valid = 2'b00; req_sub = 2'b00; rsp_ready = 1;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    test_reset;
    test_add;
    test_sub;
    test_ovf_zero;
    test_contention;
    test_backpressure;
    test_reset_exec;
    test_reset_resp;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/qadd_arbiter.md
# qadd_arbiter

Two-requester arbiter and sequencer in front of one shared sign-magnitude fixed-point adder/subtractor (qadd). It accepts operand pairs from two clients over valid/ready handshakes and grants them round-robin. It drives the single adder instance, saturates on magnitude overflow and returns a tagged, registered result over a valid/ready response port. It sits between the datapath clients and the arithmetic core, so the core is never instantiated per client.

## Interface
- N, 32, total word width; bit N-1 = sign, bits N-2:0 = magnitude
- Q, 15, fractional bits; carried to qadd only, no effect on control
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_a0 / req_a1  in  N  operand a, sign-magnitude
- req_b0 / req_b1  in  N  operand b, sign-magnitude
- req_sub  in  2  per-requester: 1 = a-b, 0 = a+b
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  1  requester index of the result
- rsp_c  out  N  result, sign-magnitude, never -0
- rsp_ovf  out  1  magnitude overflow occurred; rsp_c saturated
- busy  out  1  state != IDLE

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the requester with valid set.
  - If both are valid, grant goes to the requester not granted last (last_grant resets to 1, so req 0 wins first).
  - req_ready[g] = IDLE && req_valid[g] && grant==g (combinational).
  - On accept, register a, b XOR (sub<<(N-1)), id and sub, then go to EXEC.
- EXEC:
  - qadd sees the registered operands.
  - Overflow condition: effective signs equal and a_mag+b_mag >= 2^(N-1). On overflow, rsp_c = {sign, all-ones magnitude} and rsp_ovf=1. Otherwise rsp_c = qadd output.
  - Normalize -0 (sign=1, mag=0) to +0.
  - Register rsp_c, rsp_ovf and rsp_id; set rsp_valid; update last_grant; go to RESP.
- RESP:
  - Outputs hold stable while rsp_valid && !rsp_ready.
  - When rsp_ready is seen, clear rsp_valid and go to IDLE.
- No new request is accepted until the response handshake completes. There is no overlap of operations.
- Requesters must not drop valid or change operands before ready. The block does not depend on this for correctness: it samples only on accept.
- Reset mid-operation (any state) does the following:
  - Immediately clears rsp_valid, rsp_ovf, rsp_c, rsp_id and busy to 0.
  - Forces req_ready=0.
  - Sets last_grant=1 and returns to IDLE.
  - The in-flight op is discarded. No partial response is emitted.

## Timing
- All outputs are 0 while rst is high. req_ready is also 0 in cycle 0 after release if no valid.
- Latency: accept at edge T → rsp_valid high from T+2 (one EXEC cycle).
- Throughput: 1 op per 3 cycles when rsp_ready is held high.
- A requester held valid across two back-to-back operations loses to the other requester whenever the other is valid (strict alternation).
- rsp_ready high in the same cycle rsp_valid rises completes the handshake that edge. The next accept can then happen one cycle later, in IDLE.

## Structure
- qadd_pkg holds the state enum (IDLE/EXEC/RESP), an N-parameterised sign index localparam, and a function sm_neg0_fix() for -0 normalization.
- There is exactly one sub-module: the existing qadd #(Q,N), instantiated once and fed from the operand registers. Overflow detection and saturation live in the arbiter, not in qadd.

## Test plan
- Add: req0 a=0x0000C000 (1.5), b=0x00012000 (2.25), sub=0 → rsp_c=0x0001E000 (3.75), id=0, ovf=0, rsp_valid at accept+2.
- Subtract: req1 a=0x0000C000, b=0x00012000, sub=1 → rsp_c=0x80006000 (-0.75), id=1.
- Overflow and zero cases:
  - a=0x7FFFFFFF, b=0x00000001, add → rsp_c=0x7FFFFFFF, ovf=1.
  - a=0x80000000, b=0x80000000 → rsp_c=0x00000000.
- Contention: both valid every cycle from reset, rsp_ready=1 → ids 0,1,0,1 with 3-cycle spacing; req_ready never two-hot.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* stable, both req_ready=0, busy=1; after rsp_ready=1, IDLE next cycle.
- Reset in EXEC and in RESP (pulse not aligned to clk) → outputs 0 immediately; after release the first grant is req0.
